ram_bist_ctrl: RTL and testbench

- Sequencer directly upstream of the 32x8 synchronous RAM; drives its addr/din/w_en ports and consumes its registered dout.
- On start, writes a deterministic pattern to every location, reads every location back, compares against the expected value and reports pass/fail, error count and first failing address.
- Used for power-on memory self-test and as the bring-up fill engine for the RAM.

---
 rtl/ram_bist_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: march-style self-test sequencer for a synchronous RAM.
// It writes (addr ^ SEED) to every location and then reads every location
// back. Each read word is compared one cycle later, once the RAM's
// registered dout is valid. When the run ends it reports the result.
//
// Optional feature, enabled by the macro RAM_BIST_INVERT_PASS_EN: a second
// write/read/flush pass runs with the inverted pattern ~(addr ^ SEED).
// Errors from both passes accumulate into the same counters.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           level, sampled in IDLE; begins a run
//   ram_addr/din    RAM address / write data
//   ram_w_en        RAM write enable
//   ram_dout        RAM read data, valid one cycle after a read is issued
//   busy            high from the first WRITE cycle through the last FLUSH
//   done            one-cycle pulse when a run completes
//   pass            last run had zero mismatches (held until next start)
//   err_count       saturating mismatch count (held until next start)
//   first_err_addr  address of the first mismatch, 0 if none
module ram_bist_ctrl #(
    parameter int unsigned       ADDR_W = 5,
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       DEPTH  = 32,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(8'hA5)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_w_en,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int unsigned       CNT_W     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, FLUSH, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_d, next_addr_c, first_d;
    logic [DATA_W-1:0] din_d, mask_c, exp_c;
    logic [CNT_W-1:0]  err_d;
    logic              w_en_d, busy_d, done_d, pass_d;
    logic              finish_c, mismatch_c;

    // Compare pipeline: address read in the previous cycle and whether it was a read
    logic              cmp_en_q;
    logic [ADDR_W-1:0] prev_addr_q;

`ifdef RAM_BIST_INVERT_PASS_EN
    logic inv_q, inv_d;
    assign mask_c = {DATA_W{inv_q}};
`else
    assign mask_c = '0;
`endif

    assign next_addr_c = ram_addr + ADDR_W'(1);
    assign exp_c       = DATA_W'(prev_addr_q) ^ SEED ^ mask_c;
    assign mismatch_c  = cmp_en_q && (ram_dout != exp_c);

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        addr_d   = ram_addr;
        din_d    = ram_din;
        w_en_d   = 1'b0;
        busy_d   = busy;
        done_d   = 1'b0;
        pass_d   = pass;
        err_d    = err_count;
        first_d  = first_err_addr;
        finish_c = 1'b0;
`ifdef RAM_BIST_INVERT_PASS_EN
        inv_d    = inv_q;
`endif

        // Error accounting; cmp_en_q is only set in READ/FLUSH
        if (mismatch_c) begin
            if (err_count != '1) err_d = err_count + CNT_W'(1);
            if (err_count == '0) first_d = prev_addr_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WRITE;
                    addr_d  = '0;
                    din_d   = SEED;
                    w_en_d  = 1'b1;
                    busy_d  = 1'b1;
                    err_d   = '0;
                    first_d = '0;
                    pass_d  = 1'b0;
`ifdef RAM_BIST_INVERT_PASS_EN
                    inv_d   = 1'b0;
`endif
                end
            end
            WRITE: begin
                if (ram_addr == LAST_ADDR) begin
                    state_d = READ;
                    addr_d  = '0;
                end else begin
                    addr_d = next_addr_c;
                    din_d  = DATA_W'(next_addr_c) ^ SEED ^ mask_c;
                    w_en_d = 1'b1;
                end
            end
            READ: begin
                if (ram_addr == LAST_ADDR) state_d = FLUSH;
                else                       addr_d  = next_addr_c;
            end
            FLUSH: begin
`ifdef RAM_BIST_INVERT_PASS_EN
                if (!inv_q) begin
                    state_d = WRITE;
                    addr_d  = '0;
                    din_d   = ~SEED;
                    w_en_d  = 1'b1;
                    inv_d   = 1'b1;
                end else begin
                    finish_c = 1'b1;
                end
`else
                finish_c = 1'b1;
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Final FLUSH compare is already folded into err_d
        if (finish_c) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (err_d == '0);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            ram_addr       <= '0;
            ram_din        <= '0;
            ram_w_en       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            cmp_en_q       <= 1'b0;
            prev_addr_q    <= '0;
`ifdef RAM_BIST_INVERT_PASS_EN
            inv_q          <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            ram_addr       <= addr_d;
            ram_din        <= din_d;
            ram_w_en       <= w_en_d;
            busy           <= busy_d;
            done           <= done_d;
            pass           <= pass_d;
            err_count      <= err_d;
            first_err_addr <= first_d;
            cmp_en_q       <= (state_q == READ);
            prev_addr_q    <= ram_addr;
`ifdef RAM_BIST_INVERT_PASS_EN
            inv_q          <= inv_d;
`endif
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Testbench for ram_bist_ctrl. It contains a 32x8 synchronous RAM model
// with selectable read faults. Expected results come from a pattern model
// and are queued when a run is started, then popped when done pulses.
module tb_ram_bist_ctrl;

`ifdef RAM_BIST_INVERT_PASS_EN
    localparam int NPASS    = 2;
    localparam int DONE_CYC = 131;
`else
    localparam int NPASS    = 1;
    localparam int DONE_CYC = 66;
`endif
    localparam int LIMIT = 300;

    typedef struct {
        int errs;
        int first;
        bit ok;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] ram_addr;
    logic [7:0] ram_din;
    logic       ram_w_en;
    logic [7:0] ram_dout;
    logic       busy, done, pass;
    logic [5:0] err_count;
    logic [4:0] first_err_addr;

    int fault_mode;
    int n_checks = 0;
    int n_err    = 0;

    exp_t       exp_q[$];
    logic [7:0] din_q[$];
    logic [7:0] mem[32];

    ram_bist_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .ram_w_en       (ram_w_en),
        .ram_dout       (ram_dout),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Read-path faults: 1 = location 7 reads 0, 2 = all reads 0, 3 = location 2 bit0 stuck at 1
    function automatic logic [7:0] fault_read(input logic [7:0] w, input int a, input int mode);
        case (mode)
            1:       return (a == 7) ? 8'h00 : w;
            2:       return 8'h00;
            3:       return (a == 2) ? (w | 8'h01) : w;
            default: return w;
        endcase
    endfunction

    function automatic exp_t model(input int mode);
        exp_t e;
        logic [7:0] w;
        e.errs  = 0;
        e.first = 0;
        for (int p = 0; p < NPASS; p++) begin
            for (int a = 0; a < 32; a++) begin
                w = 8'(a) ^ 8'hA5;
                if (p == 1) w = ~w;
                if (fault_read(w, a, mode) != w) begin
                    if (e.errs == 0) e.first = a;
                    e.errs++;
                end
            end
        end
        if (e.errs > 63) e.errs = 63;
        e.ok = (e.errs == 0);
        return e;
    endfunction

    // RAM model: dout is 0 during writes, registered read otherwise
    always @(posedge clk) begin
        if (ram_w_en) begin
            mem[ram_addr] <= ram_din;
            ram_dout      <= 8'h00;
        end else begin
            ram_dout <= fault_read(mem[ram_addr], int'(ram_addr), fault_mode);
        end
    end

    // Scoreboard monitor: write data at addr 3 and results on done
    always @(negedge clk) begin
        logic [7:0] ed;
        exp_t       er;
        if (!rst) begin
            if (ram_w_en && ram_addr == 5'd3) begin
                if (din_q.size() == 0) begin
                    check("din_unexpected", 32'(ram_din), 32'hFFFF_FFFF);
                end else begin
                    ed = din_q.pop_front();
                    check("din_addr3", 32'(ram_din), 32'(ed));
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'd0);
                end else begin
                    er = exp_q.pop_front();
                    check("pass", 32'(pass), 32'(er.ok));
                    check("err_count", 32'(err_count), 32'(er.errs));
                    check("first_err_addr", 32'(first_err_addr), 32'(er.first));
                    check("busy_in_done", 32'(busy), 32'd0);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_w_en"}, 32'(ram_w_en), 32'd0);
        check({tag, "_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_din"}, 32'(ram_din), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_err"}, 32'(err_count), 32'd0);
        check({tag, "_first"}, 32'(first_err_addr), 32'd0);
    endtask

    task automatic run(input int mode, input bit repulse);
        int cyc;
        exp_q.push_back(model(mode));
        din_q.push_back(8'hA6);
        if (NPASS == 2) din_q.push_back(8'h59);
        @(negedge clk);
        fault_mode = mode;
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < LIMIT) begin
            if (cyc == 1 || cyc == DONE_CYC - 1) check("busy_active", 32'(busy), 32'd1);
            if (repulse && cyc == 40) start = 1'b1;
            if (repulse && cyc == 41) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("done_cycle", 32'(cyc), 32'(DONE_CYC));
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
    endtask

    task automatic abort_run();
        din_q.push_back(8'hA6);
        @(negedge clk);
        fault_mode = 0;
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("rst_midrun");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_done", 32'(done), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        fault_mode = 0;
        #1 rst = 1'b1;
        #1;
        check_all_zero("rst_time0");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(0, 1'b0);
        run(1, 1'b0);
        run(2, 1'b0);
        run(3, 1'b0);
        run(0, 1'b1);
        abort_run();
        run(0, 1'b0);

        repeat (3) @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("din_q_empty", 32'(din_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
